// File: rtl/board_renderer_if.sv
// Pixel, frame and palette signals shared between the playfield renderer and its driver.
// No storage; pure signal bundle.
// No flow control; the pixel stream and palette port are free-running.
interface board_renderer_if #(
    parameter int COLS = 10,
    parameter int ROWS = 22
);
    logic [COLS-1:0][ROWS-1:0][2:0] grid;
    logic [9:0]                     DrawX;
    logic [9:0]                     DrawY;
    logic                           vsync;
    logic                           clear_start;
    logic [ROWS-1:0]                clear_rows;
    logic                           pal_we;
    logic [2:0]                     pal_addr;
    logic [11:0]                    pal_data;
    logic [3:0]                     Red;
    logic [3:0]                     Green;
    logic [3:0]                     Blue;
    logic                           flash_busy;
    logic                           clear_done;

    modport master (
        output grid, DrawX, DrawY, vsync, clear_start, clear_rows,
        output pal_we, pal_addr, pal_data,
        input  Red, Green, Blue, flash_busy, clear_done
    );

    modport slave (
        input  grid, DrawX, DrawY, vsync, clear_start, clear_rows,
        input  pal_we, pal_addr, pal_data,
        output Red, Green, Blue, flash_busy, clear_done
    );
endinterface

// File: rtl/board_renderer.sv
// Renders the playfield cell colours, with optional grid lines and a line-clear flash.
// Latency: RGB for a coordinate sampled at edge N is registered at edge N+2.
// No backpressure; one pixel accepted and one produced every cycle.
module board_renderer #(
    parameter int COLS         = 10,
    parameter int ROWS         = 22,
    parameter int HIDDEN       = 2,
    parameter int CELL_LOG2    = 4,
    parameter int ORG_X        = 240,
    parameter int ORG_Y        = 80,
    parameter int GRID_LINES   = 0,
    parameter int FLASH_FRAMES = 24,
    parameter int FLASH_PERIOD = 4
) (
    input logic             Clk,
    input logic             Reset_n,
    board_renderer_if.slave bus
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    // Board extent in pixels; 12 bits so the exclusive end never overflows.
    localparam logic [11:0] X_LO = 12'(ORG_X);
    localparam logic [11:0] X_HI = 12'(ORG_X + (COLS << CELL_LOG2));
    localparam logic [11:0] Y_LO = 12'(ORG_Y);
    localparam logic [11:0] Y_HI = 12'(ORG_Y + ((ROWS - HIDDEN) << CELL_LOG2));
    localparam logic [9:0]  OX   = 10'(ORG_X);
    localparam logic [9:0]  OY   = 10'(ORG_Y);

    localparam logic [FW-1:0] LAST_FRAME = FW'(FLASH_FRAMES - 1);

    // Index 0 is the least significant entry.
    localparam logic [7:0][11:0] PAL_RST = {
        12'h707, 12'hF90, 12'hF70, 12'h00F,
        12'hF00, 12'h0F0, 12'h777, 12'hFBC
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Stage 1: decoded cell coordinates.
    logic                 in1_d,   in1_q;
    logic [CW-1:0]        col1_d,  col1_q;
    logic [RW-1:0]        row1_d,  row1_q;
    logic [CELL_LOG2-1:0] subx1_d, subx1_q;
    logic [CELL_LOG2-1:0] suby1_d, suby1_q;

    // Stage 2: colour decision flags and cell colour index.
    logic       in2_d,    in2_q;
    logic       line2_d,  line2_q;
    logic       white2_d, white2_q;
    logic [2:0] cidx2_d,  cidx2_q;

    logic [11:0]      rgb_d, rgb_q;
    logic [7:0][11:0] pal_d, pal_q;

    // Flash control.
    state_t          state_d, state_q;
    logic [FW-1:0]   frame_d, frame_q;
    logic [ROWS-1:0] mask_d,  mask_q;
    logic            busy_d,  busy_q;
    logic            done_d,  done_q;
    logic            vs_prev_d, vs_prev_q;
    logic            vs_edge;
    logic            flash_on;

    logic [9:0] dx;
    logic [9:0] dy;

    // Stage 1: board hit test and pixel-to-cell decode.
    always_comb begin
        dx      = bus.DrawX - OX;
        dy      = bus.DrawY - OY;
        in1_d   = ({2'b00, bus.DrawX} >= X_LO) && ({2'b00, bus.DrawX} < X_HI) &&
                  ({2'b00, bus.DrawY} >= Y_LO) && ({2'b00, bus.DrawY} < Y_HI);
        // Off-board pixels park the indices at zero so the grid lookup stays in range.
        col1_d  = in1_d ? CW'(dx >> CELL_LOG2) : '0;
        row1_d  = in1_d ? RW'(32'(dy >> CELL_LOG2) + $unsigned(HIDDEN)) : '0;
        subx1_d = dx[CELL_LOG2-1:0];
        suby1_d = dy[CELL_LOG2-1:0];
    end

    // Stage 2: grid lookup plus the flags that override the palette colour.
    always_comb begin
        flash_on = (state_q == FLASH) &&
                   (((32'(frame_q) / $unsigned(FLASH_PERIOD)) % 32'd2) == 32'd0);
        in2_d    = in1_q;
        line2_d  = (GRID_LINES != 0) && ((subx1_q == '0) || (suby1_q == '0));
        white2_d = flash_on && mask_q[row1_q];
        cidx2_d  = bus.grid[col1_q][row1_q];
    end

    // Output colour by priority, and the palette write port.
    always_comb begin
        rgb_d = 12'h000;
        if (!in2_q || line2_q) begin
            rgb_d = 12'h000;
        end else if (white2_q) begin
            rgb_d = 12'hFFF;
        end else begin
            rgb_d = pal_q[cidx2_q];
        end

        // The output register reads pal_q, so a write lands one cycle after its edge.
        pal_d = pal_q;
        if (bus.pal_we) begin
            pal_d[bus.pal_addr] = bus.pal_data;
        end
    end

    // Flash sequencer next state: IDLE -> FLASH for FLASH_FRAMES vsyncs -> DONE -> IDLE.
    always_comb begin
        vs_edge   = bus.vsync & ~vs_prev_q;
        vs_prev_d = bus.vsync;
        state_d   = state_q;
        frame_d   = frame_q;
        mask_d    = mask_q;
        case (state_q)
            IDLE: begin
                if (bus.clear_start && (bus.clear_rows != '0)) begin
                    mask_d  = bus.clear_rows;
                    frame_d = '0;
                    state_d = FLASH;
                end
            end
            FLASH: begin
                // The last frame exits rather than incrementing, so the counter never wraps.
                if (vs_edge) begin
                    if (frame_q == LAST_FRAME) begin
                        state_d = DONE;
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
            DONE: begin
                mask_d  = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == FLASH);
        done_d = (state_d == DONE);
    end

    // Pixel pipeline and palette registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            in1_q    <= 1'b0;
            col1_q   <= '0;
            row1_q   <= '0;
            subx1_q  <= '0;
            suby1_q  <= '0;
            in2_q    <= 1'b0;
            line2_q  <= 1'b0;
            white2_q <= 1'b0;
            cidx2_q  <= '0;
            rgb_q    <= '0;
            pal_q    <= PAL_RST;
        end else begin
            in1_q    <= in1_d;
            col1_q   <= col1_d;
            row1_q   <= row1_d;
            subx1_q  <= subx1_d;
            suby1_q  <= suby1_d;
            in2_q    <= in2_d;
            line2_q  <= line2_d;
            white2_q <= white2_d;
            cidx2_q  <= cidx2_d;
            rgb_q    <= rgb_d;
            pal_q    <= pal_d;
        end
    end

    // Flash state machine with registered status outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            mask_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vs_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            mask_q    <= mask_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            vs_prev_q <= vs_prev_d;
        end
    end

    assign bus.Red        = rgb_q[11:8];
    assign bus.Green      = rgb_q[7:4];
    assign bus.Blue       = rgb_q[3:0];
    assign bus.flash_busy = busy_q;
    assign bus.clear_done = done_q;
endmodule

// File: tb/tb_board_renderer.sv
// Directed bench: two renderers (grid lines off/on) fed the same stimulus.
// Expected colours are queued at issue time and popped by a monitor when the 2-cycle pipe delivers.
// Status outputs (flash_busy, clear_done) are compared directly at fixed points.
module tb_board_renderer;
    localparam int COLS = 10;
    localparam int ROWS = 22;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    board_renderer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();
    board_renderer_if #(.COLS(COLS), .ROWS(ROWS)) bus_g ();

    board_renderer #(.GRID_LINES(0)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    board_renderer #(.GRID_LINES(1)) dut_g (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus_g)
    );

    assign bus_g.grid        = bus.grid;
    assign bus_g.DrawX       = bus.DrawX;
    assign bus_g.DrawY       = bus.DrawY;
    assign bus_g.vsync       = bus.vsync;
    assign bus_g.clear_start = bus.clear_start;
    assign bus_g.clear_rows  = bus.clear_rows;
    assign bus_g.pal_we      = bus.pal_we;
    assign bus_g.pal_addr    = bus.pal_addr;
    assign bus_g.pal_data    = bus.pal_data;

    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    int done_base;

    logic [11:0] exp_q[$];
    string       nm_q[$];
    bit          sel_q[$];

    // Tracks which cycles carry a checked pixel through the 2-stage pipe.
    logic mark = 1'b0;
    logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
        end else begin
            v1 <= mark; v2 <= v1; v3 <= v2;
        end
    end

    // Monitor: pop and compare whenever a tracked pixel reaches the output.
    always @(negedge Clk) begin
        logic [11:0] e;
        logic [11:0] got;
        string       n;
        bit          s;
        if (v3) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_pixel: output present with empty scoreboard");
            end else begin
                e   = exp_q.pop_front();
                n   = nm_q.pop_front();
                s   = sel_q.pop_front();
                got = s ? {bus_g.Red, bus_g.Green, bus_g.Blue} : {bus.Red, bus.Green, bus.Blue};
                if (got !== e) begin
                    fails++;
                    $display("FAIL %s: rgb got %h, want %h", n, got, e);
                end
            end
        end
    end

    always @(negedge Clk) begin
        if (bus.clear_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", n, got, want);
        end
    endtask

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic [11:0] e,
                       input bit s, input string n, input bit we = 1'b0);
        @(negedge Clk);
        bus.DrawX    = x;
        bus.DrawY    = y;
        bus.pal_we   = we;
        bus.pal_addr = 3'd3;
        bus.pal_data = 12'hABC;
        mark         = 1'b1;
        exp_q.push_back(e);
        nm_q.push_back(n);
        sel_q.push_back(s);
    endtask

    task automatic idle(input int n);
        @(negedge Clk);
        mark       = 1'b0;
        bus.pal_we = 1'b0;
        repeat (n) @(negedge Clk);
    endtask

    task automatic vs_pulse();
        @(negedge Clk) bus.vsync = 1'b1;
        @(negedge Clk) bus.vsync = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    task automatic start_pulse();
        @(negedge Clk) bus.clear_start = 1'b1;
        @(negedge Clk) bus.clear_start = 1'b0;
    endtask

    initial begin
        bus.grid        = '0;
        bus.grid[0][2]  = 3'd2;
        bus.grid[1][2]  = 3'd3;
        bus.grid[2][2]  = 3'd3;
        bus.grid[0][21] = 3'd4;
        bus.grid[9][21] = 3'd5;
        bus.DrawX       = '0;
        bus.DrawY       = '0;
        bus.vsync       = 1'b0;
        bus.clear_start = 1'b0;
        bus.clear_rows  = '0;
        bus.pal_we      = 1'b0;
        bus.pal_addr    = '0;
        bus.pal_data    = '0;

        repeat (3) @(negedge Clk);
        chk("reset_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'h000);
        chk("reset_busy", 32'(bus.flash_busy), 32'd0);
        chk("reset_done", 32'(bus.clear_done), 32'd0);
        Reset_n = 1'b1;

        // Decode, board edges and grid lines.
        pix(240, 80,  12'h0F0, 0, "cell_0_2");
        pix(239, 80,  12'h000, 0, "left_of_board");
        pix(399, 399, 12'hF70, 0, "bottom_right_cell");
        pix(400, 399, 12'h000, 0, "right_edge");
        pix(399, 400, 12'h000, 0, "bottom_edge");
        pix(240, 79,  12'h000, 0, "above_board");
        pix(256, 90,  12'hF00, 0, "no_grid_lines");
        pix(256, 90,  12'h000, 1, "grid_line_x0");
        pix(257, 90,  12'hF00, 1, "grid_cell_interior");
        pix(257, 96,  12'h000, 1, "grid_line_y0");
        idle(4);

        // Palette write lands on the sample edge of the third pixel; the first
        // pixel's output register fires on that same edge and must see F00.
        pix(257, 90, 12'hF00, 0, "pal_same_cycle_old");
        pix(272, 90, 12'hABC, 0, "pal_next_cycle_new");
        pix(257, 90, 12'hABC, 0, "pal_write_cycle", 1'b1);
        pix(272, 90, 12'hABC, 0, "pal_persist");
        pix(257, 90, 12'hABC, 1, "pal_grid_dut");
        idle(4);

        // Full flash on row 21, with an ignored restart at frame 5.
        bus.clear_rows     = '0;
        bus.clear_rows[21] = 1'b1;
        start_pulse();
        done_base = done_cnt;
        for (int f = 0; f < 24; f++) begin
            chk($sformatf("busy_f%0d", f), 32'(bus.flash_busy), 32'd1);
            if (f == 5) begin
                bus.clear_rows    = '0;
                bus.clear_rows[2] = 1'b1;
                start_pulse();
            end
            pix(240, 384, (((f / 4) % 2) == 0) ? 12'hFFF : 12'h00F, 0, $sformatf("row21_f%0d", f));
            pix(240, 80, 12'h0F0, 0, $sformatf("row2_f%0d", f));
            idle(4);
            vs_pulse();
        end
        idle(2);
        chk("busy_after_flash", 32'(bus.flash_busy), 32'd0);
        chk("clear_done_pulses", 32'(done_cnt - done_base), 32'd1);

        // Empty mask request is ignored.
        bus.clear_rows = '0;
        start_pulse();
        idle(2);
        chk("busy_empty_mask", 32'(bus.flash_busy), 32'd0);
        pix(240, 384, 12'h00F, 0, "row21_idle");
        idle(4);

        // Reset at frame 10 of a flash.
        bus.clear_rows[21] = 1'b1;
        start_pulse();
        for (int f = 0; f < 10; f++) vs_pulse();
        pix(240, 384, 12'hFFF, 0, "row21_f10_pre_reset");
        idle(4);
        done_base = done_cnt;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("midflash_reset_rgb", 32'({bus.Red, bus.Green, bus.Blue}), 32'h000);
        chk("midflash_reset_busy", 32'(bus.flash_busy), 32'd0);
        chk("midflash_reset_done", 32'(bus.clear_done), 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        pix(240, 384, 12'h00F, 0, "row21_after_reset");
        pix(257, 90,  12'hF00, 0, "pal_restored");
        idle(4);
        for (int f = 0; f < 16; f++) vs_pulse();
        chk("busy_after_reset", 32'(bus.flash_busy), 32'd0);
        chk("no_done_after_reset", 32'(done_cnt - done_base), 32'd0);

        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: %0d expected pixels never arrived, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/board_renderer.md
BOARD_RENDERER -- requirements
Module: board_renderer

Interface
REQ-001 SHALL have parameter COLS, default 10: board columns.
REQ-002 SHALL have parameter ROWS, default 22: board rows, including hidden rows.
REQ-003 SHALL have parameter HIDDEN, default 2: top rows never drawn.
REQ-004 SHALL have parameter CELL_LOG2, default 4: cell edge is 2^CELL_LOG2 pixels.
REQ-005 SHALL have parameters ORG_X=240 and ORG_Y=80: pixel of the visible board's top-left corner.
REQ-006 SHALL have parameter GRID_LINES, default 0: 1 draws black cell borders.
REQ-007 SHALL have parameter FLASH_FRAMES, default 24: length of the line-clear flash, in frames.
REQ-008 SHALL have parameter FLASH_PERIOD, default 4: frames per flash on- or off-phase.
REQ-009 SHALL have port Clk, input, 1 bit: the single clock; every register is clocked on the rising edge.
REQ-010 SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port grid, input, [2:0] x COLS x ROWS: cell colour indices.
REQ-012 SHALL have ports DrawX and DrawY, input, 10 bits each: current pixel coordinate.
REQ-013 SHALL have port vsync, input, 1 bit: the frame marker, used on its rising edge.
REQ-014 SHALL have port clear_start, input, 1 bit: pulse that requests a flash.
REQ-015 SHALL have port clear_rows, input, ROWS bits: mask of rows to flash; bit r is grid row r.
REQ-016 SHALL have ports pal_we (1 bit), pal_addr (3 bits) and pal_data (12 bits {R,G,B}), inputs: palette write port.
REQ-017 SHALL have ports Red, Green and Blue, output, 4 bits each: registered pixel colour.
REQ-018 SHALL have port flash_busy, output, 1 bit: high while the state machine is in FLASH.
REQ-019 SHALL have port clear_done, output, 1 bit: one-cycle completion pulse.

Function
REQ-020 SHALL render with a fixed 2-cycle latency: the RGB for the DrawX/DrawY sampled at edge N appears after edge N+2.
REQ-021 Stage 1 SHALL register: in_board, col = (DrawX-ORG_X)>>CELL_LOG2, row = ((DrawY-ORG_Y)>>CELL_LOG2)+HIDDEN, and the low CELL_LOG2 bits of each offset.
REQ-022 SHALL set in_board when ORG_X<=DrawX<ORG_X+COLS*2^CELL_LOG2 and ORG_Y<=DrawY<ORG_Y+(ROWS-HIDDEN)*2^CELL_LOG2, using unsigned compares.
REQ-023 Stage 2 SHALL select the colour by strict priority:
  - not in_board -> 000;
  - GRID_LINES=1 and either sub-offset is 0 -> 000;
  - flash on-phase and clear_mask[row]=1 -> FFF;
  - otherwise palette[grid[col][row]].
REQ-024 SHALL hold an 8x12-bit palette with reset contents: 0=FBC, 1=777, 2=0F0, 3=F00, 4=00F, 5=F70, 6=F90, 7=707.
REQ-025 SHALL write pal_data to palette[pal_addr] on a clock edge when pal_we=1.
REQ-026 A palette write SHALL be seen by stage 2 from the next cycle onward; a same-cycle read returns the old value.
REQ-027 SHALL detect vsync rising edges with a registered previous-vsync bit; the edge is a one-cycle event.
REQ-028 SHALL use a state machine with states IDLE, FLASH and DONE.
REQ-029 IDLE: clear_start=1 with clear_rows!=0 SHALL latch clear_rows into clear_mask, zero frame_cnt, and go to FLASH.
REQ-030 IDLE: clear_start=1 with clear_rows=0 SHALL be ignored.
REQ-031 FLASH: each vsync edge SHALL increment frame_cnt.
REQ-032 FLASH: on the vsync edge where frame_cnt=FLASH_FRAMES-1, the state SHALL go to DONE.
REQ-033 FLASH: clear_start SHALL be ignored, and clear_mask SHALL be held.
REQ-034 The flash on-phase SHALL be the condition (frame_cnt/FLASH_PERIOD) even, evaluated only in FLASH.
REQ-035 DONE SHALL assert clear_done for exactly one cycle, clear clear_mask, and return to IDLE.
REQ-036 flash_busy SHALL equal (state==FLASH).
REQ-037 frame_cnt SHALL be wide enough to hold FLASH_FRAMES-1 and SHALL never wrap within a flash.

Reset
REQ-038 Reset_n low SHALL asynchronously force:
  - Red/Green/Blue=0;
  - both pipeline stages cleared (in_board=0);
  - state=IDLE, frame_cnt=0, clear_mask=0;
  - flash_busy=0, clear_done=0, previous-vsync=0;
  - palette restored to the reset contents.
REQ-039 Reset asserted mid-flash SHALL abort the flash with no clear_done pulse.
REQ-040 The first valid RGB after reset release SHALL appear 2 cycles after the first sampled coordinate.

Verification
REQ-041 Bench SHALL cover: grid[0][2]=2, DrawX=240, DrawY=80 -> RGB=0F0 exactly 2 cycles later; DrawX=239 -> 000.
REQ-042 Bench SHALL cover: GRID_LINES=1, DrawX=256, DrawY=90, grid cell=3 -> 000; DrawX=257 -> F00.
REQ-043 Bench SHALL cover: pal_we=1, pal_addr=3, pal_data=ABC, then sweep cells holding 3 -> ABC appears from the next cycle, and the same-cycle read returns F00.
REQ-044 Bench SHALL cover: clear_rows bit 21 set, clear_start pulse, 24 vsync edges -> row 21 is FFF in frames 0-3, 8-11 and 16-19 and palette colour otherwise; flash_busy is high for 24 frames; one clear_done pulse.
REQ-045 Bench SHALL cover: clear_start during FLASH with a different mask -> ignored, and clear_mask is unchanged.
REQ-046 Bench SHALL cover: Reset_n low at frame 10 of a flash -> state=IDLE, RGB=0, palette at reset contents, and no clear_done pulse.
